// File: rtl/fast_square_pkg.sv
// Shared definitions for the fast-square step framer: FSM encoding, framing words
// and header field widths.
package fast_square_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_DATA  = 2'd2,
    ST_TRAIL = 2'd3
  } state_e;

  localparam int SAMPLE_W  = 16;
  localparam int CNT_W     = 16;
  localparam int STEP_W    = 5;
  localparam int HDR_PAD_W = SAMPLE_W - STEP_W;

  localparam logic [SAMPLE_W-1:0] DEF_SYNC_WORD  = 16'hA5A5;
  localparam logic [SAMPLE_W-1:0] DEF_TRAIL_WORD = 16'h5A5A;

  // Header Q word: step index in the top bits, zero padding below.
  function automatic logic [SAMPLE_W-1:0] hdr_q(input logic [STEP_W-1:0] idx);
    return {idx, {HDR_PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fast_square_step_counter.sv
// Modulo-NUM_STEPS step index counter; clear wins over increment.
module fast_square_step_counter
  import fast_square_pkg::*;
#(
  parameter int NUM_STEPS = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [STEP_W-1:0] o_idx
);

  localparam logic [STEP_W-1:0] LAST = STEP_W'(NUM_STEPS - 1);

  logic [STEP_W-1:0] r_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_idx <= '0;
    else if (i_clr)  r_idx <= '0;
    else if (i_inc)  r_idx <= (r_idx == LAST) ? '0 : r_idx + STEP_W'(1);
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/fast_square_step_framer.sv
// Frames recorded I/Q windows with a sync header (carrying the step index) and a
// trailer carrying the saturating sample count.
module fast_square_step_framer
  import fast_square_pkg::*;
#(
  parameter int                  NUM_STEPS  = 32,
  parameter logic [SAMPLE_W-1:0] SYNC_WORD  = DEF_SYNC_WORD,
  parameter logic [SAMPLE_W-1:0] TRAIL_WORD = DEF_TRAIL_WORD
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                step_reset,
  input  logic                step,
  input  logic                record,
  input  logic                in_strobe,
  input  logic [SAMPLE_W-1:0] i_in,
  input  logic [SAMPLE_W-1:0] q_in,
  output logic                out_strobe,
  output logic [SAMPLE_W-1:0] i_out,
  output logic [SAMPLE_W-1:0] q_out,
  output logic [STEP_W-1:0]   step_idx,
  output logic                overflow
);

  state_e              r_state;
  logic                r_record_d;
  logic                r_pending;
  logic                r_overflow;
  logic                r_out_strobe;
  logic [SAMPLE_W-1:0] r_i_out;
  logic [SAMPLE_W-1:0] r_q_out;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_rec_rise;
  logic [STEP_W-1:0]   w_step_idx;

  assign w_rec_rise = record & ~r_record_d;

  fast_square_step_counter #(
    .NUM_STEPS(NUM_STEPS)
  ) u_step_cnt (
    .clock (clock),
    .reset (reset),
    .i_clr (step_reset),
    .i_inc (step),
    .o_idx (w_step_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_record_d   <= 1'b0;
      r_pending    <= 1'b0;
      r_overflow   <= 1'b0;
      r_out_strobe <= 1'b0;
      r_i_out      <= '0;
      r_q_out      <= '0;
      r_cnt        <= '0;
    end else begin
      r_record_d   <= record;
      r_out_strobe <= 1'b0;
      if (!enable) begin
        r_state   <= ST_IDLE;
        r_pending <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (w_rec_rise) r_state <= ST_HDR;
          // Header consumes the strobe; the sample it came with is dropped.
          ST_HDR: if (in_strobe) begin
            r_out_strobe <= 1'b1;
            r_i_out      <= SYNC_WORD;
            r_q_out      <= hdr_q(w_step_idx);
            r_cnt        <= '0;
            r_state      <= ST_DATA;
          end
          ST_DATA: begin
            if (!record) begin
              r_state <= ST_TRAIL;
            end else if (in_strobe) begin
              r_out_strobe <= 1'b1;
              r_i_out      <= i_in;
              r_q_out      <= q_in;
              if (r_cnt == '1) r_overflow <= 1'b1;
              else             r_cnt      <= r_cnt + CNT_W'(1);
            end
          end
          // A new window opened during TRAIL is remembered so it follows the trailer.
          ST_TRAIL: begin
            if (in_strobe) begin
              r_out_strobe <= 1'b1;
              r_i_out      <= TRAIL_WORD;
              r_q_out      <= r_cnt;
              r_pending    <= 1'b0;
              r_state      <= (r_pending | w_rec_rise) ? ST_HDR : ST_IDLE;
            end else if (w_rec_rise) begin
              r_pending <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_strobe = r_out_strobe;
  assign i_out      = r_i_out;
  assign q_out      = r_q_out;
  assign step_idx   = w_step_idx;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_fast_square_step_framer.sv
// Directed bench for fast_square_step_framer: framing, step wrap, window re-fire,
// enable drop, async reset and count saturation.
module tb_fast_square_step_framer;

  logic        clock = 1'b0;
  logic        reset, enable, step_reset, step, record, in_strobe;
  logic [15:0] i_in, q_in;
  logic        out_strobe;
  logic [15:0] i_out, q_out;
  logic [4:0]  step_idx;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  fast_square_step_framer dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .step_reset (step_reset),
    .step       (step),
    .record     (record),
    .in_strobe  (in_strobe),
    .i_in       (i_in),
    .q_in       (q_in),
    .out_strobe (out_strobe),
    .i_out      (i_out),
    .q_out      (q_out),
    .step_idx   (step_idx),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [15:0] a, input logic [15:0] b);
    in_strobe = 1'b1;
    i_in      = a;
    q_in      = b;
    cyc();
    in_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; step_reset = 1'b0; step = 1'b0;
    record = 1'b0; in_strobe = 1'b0; i_in = '0; q_in = '0;
    cyc(); cyc();
    checks++;
    if ({out_strobe, i_out, q_out, step_idx, overflow} !== 39'd0) begin
      errors++;
      $display("FAIL reset_state: got s=%b i=%h q=%h idx=%0d ovf=%b, want all 0",
               out_strobe, i_out, q_out, step_idx, overflow);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    step = 1'b1; cyc(); cyc(); cyc(); step = 1'b0;
    checks++;
    if (step_idx !== 5'd3) begin
      errors++; $display("FAIL step_count: got %0d want 3", step_idx);
    end
    record = 1'b1; cyc();
    for (int k = 0; k < 10; k++) begin
      strobe(16'h1000 + 16'(k), 16'h2000 + 16'(k));
      checks++;
      if (k == 0) begin
        if ({out_strobe, i_out, q_out} !== {1'b1, 16'hA5A5, 16'h1800}) begin
          errors++;
          $display("FAIL basic_hdr: got %b %h %h want 1 a5a5 1800", out_strobe, i_out, q_out);
        end
      end else if ({out_strobe, i_out, q_out} !== {1'b1, 16'h1000 + 16'(k), 16'h2000 + 16'(k)}) begin
        errors++;
        $display("FAIL basic_data%0d: got %b %h %h", k, out_strobe, i_out, q_out);
      end
    end
    cyc();
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b0, 16'h1009, 16'h2009}) begin
      errors++;
      $display("FAIL basic_hold: got %b %h %h want 0 1009 2009", out_strobe, i_out, q_out);
    end
    record = 1'b0; cyc();
    strobe(16'hDEAD, 16'hBEEF);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b1, 16'h5A5A, 16'h0009}) begin
      errors++;
      $display("FAIL basic_trail: got %b %h %h want 1 5a5a 0009", out_strobe, i_out, q_out);
    end
    strobe(16'hDEAD, 16'hBEEF);
    checks++;
    if (out_strobe !== 1'b0) begin
      errors++; $display("FAIL idle_quiet: got out_strobe %b want 0", out_strobe);
    end
  endtask

  task automatic test_wrap();
    step = 1'b1; step_reset = 1'b1; cyc(); step = 1'b0; step_reset = 1'b0;
    checks++;
    if (step_idx !== 5'd0) begin
      errors++; $display("FAIL clr_priority: got %0d want 0", step_idx);
    end
    step = 1'b1; repeat (31) cyc(); step = 1'b0;
    checks++;
    if (step_idx !== 5'd31) begin
      errors++; $display("FAIL step31: got %0d want 31", step_idx);
    end
    step = 1'b1; record = 1'b1; cyc(); step = 1'b0;
    checks++;
    if (step_idx !== 5'd0) begin
      errors++; $display("FAIL step_wrap: got %0d want 0", step_idx);
    end
    strobe(16'h1111, 16'h1111);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b1, 16'hA5A5, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_hdr: got %b %h %h want 1 a5a5 0000", out_strobe, i_out, q_out);
    end
    record = 1'b0; cyc();
    strobe(16'h2222, 16'h2222);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b1, 16'h5A5A, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_trail: got %b %h %h want 1 5a5a 0000", out_strobe, i_out, q_out);
    end
  endtask

  task automatic test_hdr_fall();
    record = 1'b1; cyc(); record = 1'b0; cyc();
    strobe(16'h1234, 16'h5678);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b1, 16'hA5A5, 16'h0000}) begin
      errors++;
      $display("FAIL hfall_hdr: got %b %h %h want 1 a5a5 0000", out_strobe, i_out, q_out);
    end
    strobe(16'h1234, 16'h5678);
    checks++;
    if (out_strobe !== 1'b0) begin
      errors++; $display("FAIL hfall_nopass: got out_strobe %b want 0", out_strobe);
    end
    strobe(16'h1234, 16'h5678);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b1, 16'h5A5A, 16'h0000}) begin
      errors++;
      $display("FAIL hfall_trail: got %b %h %h want 1 5a5a 0000", out_strobe, i_out, q_out);
    end
  endtask

  task automatic test_refire();
    record = 1'b1; cyc();
    strobe(16'h0, 16'h0);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b1, 16'hA5A5, 16'h0000}) begin
      errors++;
      $display("FAIL refire_hdr1: got %b %h %h want 1 a5a5 0000", out_strobe, i_out, q_out);
    end
    strobe(16'h0A01, 16'h0B01);
    step = 1'b1; cyc(); step = 1'b0;
    checks++;
    if (step_idx !== 5'd1) begin
      errors++; $display("FAIL refire_step: got %0d want 1", step_idx);
    end
    strobe(16'h0A02, 16'h0B02);
    strobe(16'h0A03, 16'h0B03);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b1, 16'h0A03, 16'h0B03}) begin
      errors++;
      $display("FAIL refire_data: got %b %h %h want 1 0a03 0b03", out_strobe, i_out, q_out);
    end
    record = 1'b0; cyc(); record = 1'b1; cyc();
    strobe(16'hFFFF, 16'hFFFF);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b1, 16'h5A5A, 16'h0003}) begin
      errors++;
      $display("FAIL refire_trail: got %b %h %h want 1 5a5a 0003", out_strobe, i_out, q_out);
    end
    strobe(16'hFFFF, 16'hFFFF);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b1, 16'hA5A5, 16'h0800}) begin
      errors++;
      $display("FAIL refire_hdr2: got %b %h %h want 1 a5a5 0800", out_strobe, i_out, q_out);
    end
    strobe(16'h0C01, 16'h0D01);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b1, 16'h0C01, 16'h0D01}) begin
      errors++;
      $display("FAIL refire_data2: got %b %h %h want 1 0c01 0d01", out_strobe, i_out, q_out);
    end
    record = 1'b0; cyc();
    strobe(16'h0, 16'h0);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b1, 16'h5A5A, 16'h0001}) begin
      errors++;
      $display("FAIL refire_trail2: got %b %h %h want 1 5a5a 0001", out_strobe, i_out, q_out);
    end
  endtask

  task automatic test_enable();
    record = 1'b1; cyc();
    strobe(16'h0, 16'h0);
    strobe(16'h1111, 16'h2222);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b1, 16'h1111, 16'h2222}) begin
      errors++;
      $display("FAIL en_data: got %b %h %h want 1 1111 2222", out_strobe, i_out, q_out);
    end
    enable = 1'b0; cyc();
    strobe(16'h3333, 16'h4444);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b0, 16'h1111, 16'h2222}) begin
      errors++;
      $display("FAIL en_low: got %b %h %h want 0 1111 2222", out_strobe, i_out, q_out);
    end
    enable = 1'b1; cyc();
    strobe(16'h3333, 16'h4444);
    checks++;
    if (out_strobe !== 1'b0 || step_idx !== 5'd1) begin
      errors++;
      $display("FAIL en_rehigh: got s=%b idx=%0d want s=0 idx=1", out_strobe, step_idx);
    end
    record = 1'b0; cyc(); record = 1'b1; cyc();
    strobe(16'h0, 16'h0);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b1, 16'hA5A5, 16'h0800}) begin
      errors++;
      $display("FAIL en_hdr: got %b %h %h want 1 a5a5 0800", out_strobe, i_out, q_out);
    end
    record = 1'b0; cyc();
    strobe(16'h0, 16'h0);
    checks++;
    if ({out_strobe, i_out, q_out, overflow} !== {1'b1, 16'h5A5A, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL en_trail: got %b %h %h ovf=%b want 1 5a5a 0000 0",
               out_strobe, i_out, q_out, overflow);
    end
  endtask

  task automatic test_reset_mid();
    record = 1'b1; cyc();
    strobe(16'h0, 16'h0);
    strobe(16'h3333, 16'h4444);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_strobe, i_out, q_out, step_idx} !== 38'd0) begin
      errors++;
      $display("FAIL async_reset: got s=%b i=%h q=%h idx=%0d want all 0",
               out_strobe, i_out, q_out, step_idx);
    end
    record = 1'b0; cyc(); cyc(); reset = 1'b0; cyc();
    for (int k = 0; k < 3; k++) begin
      strobe(16'h5555, 16'h6666);
      checks++;
      if (out_strobe !== 1'b0) begin
        errors++; $display("FAIL post_reset_quiet%0d: got out_strobe %b want 0", k, out_strobe);
      end
    end
    record = 1'b1; cyc();
    strobe(16'h0, 16'h0);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b1, 16'hA5A5, 16'h0000}) begin
      errors++;
      $display("FAIL post_reset_hdr: got %b %h %h want 1 a5a5 0000", out_strobe, i_out, q_out);
    end
    record = 1'b0; cyc();
    strobe(16'h0, 16'h0);
  endtask

  task automatic test_overflow();
    record = 1'b1; cyc();
    in_strobe = 1'b1; i_in = 16'h7777; q_in = 16'h8888;
    repeat (70000) cyc();
    in_strobe = 1'b0;
    checks++;
    if ({out_strobe, i_out, q_out, overflow} !== {1'b1, 16'h7777, 16'h8888, 1'b1}) begin
      errors++;
      $display("FAIL ovf_data: got %b %h %h ovf=%b want 1 7777 8888 1",
               out_strobe, i_out, q_out, overflow);
    end
    record = 1'b0; cyc();
    strobe(16'h0, 16'h0);
    checks++;
    if ({out_strobe, i_out, q_out} !== {1'b1, 16'h5A5A, 16'hFFFF}) begin
      errors++;
      $display("FAIL ovf_trail: got %b %h %h want 1 5a5a ffff", out_strobe, i_out, q_out);
    end
    repeat (5) cyc();
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b want 0", overflow);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_hdr_fall();
    test_refire();
    test_enable();
    test_reset_mid();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
